mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: none; all encodings come from the shared package.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces FETCH immediately.
REQ-004 op  in  7  instruction opcode from the instruction register.
REQ-005 funct3  in  3  instruction funct3. funct7b5  in  1  instruction bit 30.
REQ-006 Zero  in  1  ALU zero flag. MemReady  in  1  unified memory completes the current access this cycle.
REQ-007 PCWrite  out  1  = PCUpdate OR (Branch AND Zero). AdrSrc  out  1  0 = PC, 1 = ALU result register.
REQ-008 MemWrite, IRWrite, RegWrite  out  1 each  write strobes.
REQ-009 ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result, 11 ImmExt.
REQ-010 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1. ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
REQ-011 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U. ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI. Outputs are combinational from state; the MemReady-gated strobes also depend on MemReady.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate SHALL assert only when MemReady=1. FETCH SHALL hold while MemReady=0 and go to DECODE when MemReady=1.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: 0000011/0100011 to MEMADR; 0110011 to EXECUTER; 0010011 to EXECUTEI; 1100011 to BEQ; 1101111 to JAL; 0110111 to LUI. Any other op SHALL go to FETCH with no write strobe.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op[5]=0, otherwise MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; holds until MemReady=1, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1; then FETCH.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; holds with MemWrite asserted until MemReady=1, then FETCH.
REQ-018 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegWrite=1; then FETCH.
REQ-020 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; then FETCH.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; then ALUWB.
REQ-022 LUI: ResultSrc=11, RegWrite=1; then FETCH.
REQ-023 Outputs not listed for a state SHALL be 0; no output is ever X.
REQ-024 ImmSrc SHALL decode combinationally from op (lw/I-ALU 000, sw 001, beq 010, jal 011, lui 100, other 000).
REQ-025 ALU decode: ALUOp 00 gives add; 01 gives sub; 10 decodes funct3: 000 gives sub if op[5] AND funct7b5, otherwise add; 010 gives slt; 110 gives or; 111 gives and; any other funct3 gives add.
REQ-026 Latency per instruction with zero wait states: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 3 cycles.

Reset
REQ-027 reset SHALL set the state to FETCH asynchronously, including mid-instruction; a pending MemWrite SHALL deassert immediately.
REQ-028 While reset is high, outputs SHALL equal the FETCH values with IRWrite=0, PCUpdate=0 and PCWrite=0.

Configuration
REQ-029 Macro MC_CTRL_LUI_EN: when defined, the LUI state and transition exist. When undefined, op 0110111 SHALL be treated as unknown (DECODE goes to FETCH) and ResultSrc=11 is never driven.

Structure
REQ-030 The package mc_ctrl_pkg SHALL hold the state enum, the opcode constants, and the ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-031 The ALU decode SHALL be the sub-module aludec (inputs ALUOp, funct3, funct7b5, op5; output ALUControl).

Verification
REQ-032 lw with MemReady=1 throughout: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-033 sw with MemReady low for 3 cycles in MEMWRITE: MemWrite high for 4 consecutive cycles, then FETCH.
REQ-034 beq with Zero=1, then with Zero=0: PCWrite=1, ALUControl=001 in cycle 3 for the first; PCWrite=0 in cycle 3 for the second.
REQ-035 R-type sub (funct3=000, funct7b5=1) gives ALUControl=001 in EXECUTER. I-type addi with funct7b5=1 gives ALUControl=000.
REQ-036 Assert reset in the MEMREAD cycle: next observed state is FETCH and RegWrite never asserts. FETCH with MemReady=0 for 2 cycles: IRWrite and PCWrite stay 0 until MemReady=1.
REQ-037 op=0110111: goes to LUI and asserts RegWrite with ResultSrc=11 when MC_CTRL_LUI_EN is defined; returns DECODE to FETCH with no write when it is undefined.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: state codes, opcodes and datapath mux selects.
// The optional LUI path is enabled by defining MC_CTRL_LUI_EN.
package mc_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_LUI      = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE: imm = IMM_S;
            OP_BEQ:   imm = IMM_B;
            OP_JAL:   imm = IMM_J;
`ifdef MC_CTRL_LUI_EN
            OP_LUI:   imm = IMM_U;
`endif
            default:  imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's ALUOp plus instruction fields onto an ALUControl code.
module aludec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl
);

    // Only register-register ops with bit 30 set subtract; addi ignores bit 30.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 && funct7b5) begin
                            ALUControl = ALU_SUB;
                        end else begin
                            ALUControl = ALU_ADD;
                        end
                    end
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle RISC-V core sharing one memory for fetch and data.
// Define MC_CTRL_LUI_EN to include the LUI state.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; memory states wait on MemReady.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (MemReady) begin
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
`ifdef MC_CTRL_LUI_EN
                    OP_LUI:            next_state = S_LUI;
`endif
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op[5]) begin
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (MemReady) begin
                    next_state = S_MEMWB;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_MEMWRITE;
                end
            end
            S_EXECUTER, S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:                  next_state = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: next_state = S_FETCH;
`ifdef MC_CTRL_LUI_EN
            S_LUI:                  next_state = S_FETCH;
`endif
            default:                next_state = S_FETCH;
        endcase
    end

    // Per-state output decode; everything not named for a state stays 0.
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                // Reset already holds the state in FETCH; it must also hold off the fetch strobes.
                IRWrite   = MemReady & ~reset;
                pc_update = MemReady & ~reset;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef MC_CTRL_LUI_EN
            S_LUI: begin
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
            end
`endif
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign ImmSrc  = imm_src_of(op);

    aludec u_aludec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected cycle schedules built from the instruction rules.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        logic        mr;
        logic        z;
        logic [16:0] exp;
        string       tag;
    } cyc_t;

    cyc_t sched[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] UNK = 7'b1110011;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // Expected output word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
    function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw, input logic irw,
                                       input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] imm, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
    endfunction

    function automatic logic [2:0] imm_model(input logic [6:0] o);
        if (o == SW) return 3'b001;
        if (o == BQ) return 3'b010;
        if (o == JL) return 3'b011;
`ifdef MC_CTRL_LUI_EN
        if (o == LU) return 3'b100;
`endif
        return 3'b000;
    endfunction

    function automatic logic [2:0] alu_exec(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push(input logic mr, input logic z, input logic [16:0] e, input string tag);
        cyc_t c;
        c.mr = mr; c.z = z; c.exp = e; c.tag = tag;
        sched.push_back(c);
    endtask

    task automatic chk(input string tag, input logic [16:0] e);
        logic [16:0] obs;
        obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
        chk_cnt++;
        assert (obs === e) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Runs one instruction from FETCH; stop_at >= 0 leaves the FSM mid-instruction after that many cycles.
    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                         input int fw, input int mw, input int stop_at);
        logic [2:0] im;
        logic [16:0] wb;
        int n;
        im = imm_model(o);
        wb = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, im, 3'b000);
        sched.delete();
        for (int i = 0; i < fw; i++)
            push(1'b0, rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, im, 3'b000), "fetch_wait");
        push(1'b1, rbit(), ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, im, 3'b000), "fetch");
        push(rbit(), rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 3'b000), "decode");
        if (o == LW || o == SW)
            push(rbit(), rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 3'b000), "memadr");
        if (o == LW) begin
            for (int i = 0; i < mw; i++)
                push(1'b0, rbit(), ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 3'b000), "memread_wait");
            push(1'b1, rbit(), ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 3'b000), "memread");
            push(rbit(), rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, im, 3'b000), "memwb");
        end else if (o == SW) begin
            for (int i = 0; i < mw; i++)
                push(1'b0, rbit(), ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 3'b000), "memwrite_wait");
            push(1'b1, rbit(), ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 3'b000), "memwrite");
        end else if (o == RT || o == IT) begin
            push(rbit(), rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00,
                                    im, alu_exec(o, f3, f7)), "execute");
            push(rbit(), rbit(), wb, "aluwb");
        end else if (o == BQ) begin
            push(rbit(), z, ev(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, im, 3'b001), "beq");
        end else if (o == JL) begin
            push(rbit(), rbit(), ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, im, 3'b000), "jal");
            push(rbit(), rbit(), wb, "aluwb");
        end
`ifdef MC_CTRL_LUI_EN
        else if (o == LU) begin
            push(rbit(), rbit(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, im, 3'b000), "lui");
        end
`endif
        n = (stop_at < 0) ? sched.size() : stop_at;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op = o; funct3 = f3; funct7b5 = f7;
            MemReady = sched[i].mr;
            Zero = sched[i].z;
            #1;
            chk(sched[i].tag, sched[i].exp);
        end
    endtask

    // Raise reset mid-cycle, hold it a cycle, then release into FETCH with memory stalled.
    task automatic do_reset();
        logic [16:0] fv;
        fv = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm_model(op), 3'b000);
        reset = 1'b1;
        MemReady = 1'b1;
        Zero = 1'b1;
        #1;
        chk("reset_immediate", fv);
        @(negedge clk);
        #1;
        chk("reset_held", fv);
        @(negedge clk);
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        chk("fetch_after_reset", fv);
    endtask

    initial begin
        logic [6:0] ops [8];
        int k;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT;
        ops[4] = BQ; ops[5] = JL; ops[6] = LU; ops[7] = UNK;
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
        do_reset();

        instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, -1);
        instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, -1);
        instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        instr(RT, 3'b010, 1'b0, 1'b0, 0, 0, -1);
        instr(RT, 3'b110, 1'b0, 1'b0, 0, 0, -1);
        instr(IT, 3'b111, 1'b0, 1'b0, 0, 0, -1);
        instr(LW, 3'b010, 1'b0, 1'b0, 2, 1, -1);
        instr(JL, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        instr(LU, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        instr(UNK, 3'b000, 1'b0, 1'b0, 0, 0, -1);

        // lw interrupted in MEMREAD, sw interrupted while MemWrite is high.
        instr(LW, 3'b010, 1'b0, 1'b0, 0, 2, 4);
        do_reset();
        instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, 4);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(7, 0);
            instr(ops[k], 3'($urandom_range(7, 0)), rbit(), rbit(),
                  $urandom_range(3, 0), $urandom_range(3, 0), -1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
